// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_timer peripheral.
//   - register word addresses (addr[3:2] of the core's byte address)
//   - CTRL bit positions and MODE encodings
//   - FSM state encoding
package tc_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/tc_timer_if.sv
// tc_timer_if: data-side bus between the MIPS core (master) and the timer
// (slave).
//   addr    : word select (byte address bits [3:2])
//   wr      : one-cycle store strobe
//   wr_data : store data
//   rd_data : combinational load data for addr
//   irq     : level interrupt request toward the core's exception logic
interface tc_timer_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              irq;

  modport master (
    output addr, wr, wr_data,
    input  rd_data, irq
  );

  modport slave (
    input  addr, wr, wr_data,
    output rd_data, irq
  );
endinterface

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped count-down timer with interrupt.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : tc_timer_if.slave (addr, wr, wr_data in; rd_data, irq out)
// Registers: CTRL (EN, MODE, IM), PRESET (r/w), COUNT (read-only).
// COUNT is loaded from PRESET in LOAD, decrements in CNT and the block
// raises irq on reaching terminal count.
module tc_timer
  import tc_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  tc_timer_if.slave bus
);

  tc_state_e         state_q, state_d;
  logic              en_q, en_d;
  logic [1:0]        mode_q, mode_d;
  logic              im_q, im_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              flag_q, flag_d;

  logic [ADDR_W-1:0] addr;
  logic              ctrl_wr;
  logic              preset_wr;
  logic              oneshot;
  logic              enter_int;
  logic [31:0]       rd_data;

  assign addr      = bus.addr;
  assign ctrl_wr   = bus.wr && (addr == ADDR_W'(TC_CTRL));
  assign preset_wr = bus.wr && (addr == ADDR_W'(TC_PRESET));
  // MODE 1x behaves like one-shot, so only the exact reload code reloads.
  assign oneshot   = (mode_q != MODE_RELOAD);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    enter_int = 1'b0;

    if (ctrl_wr) begin
      en_d   = bus.wr_data[CTRL_EN_BIT];
      mode_d = bus.wr_data[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d   = bus.wr_data[CTRL_IM_BIT];
    end
    if (preset_wr) begin
      preset_d = bus.wr_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers both COUNT == 1 and a zero PRESET; never wraps.
          count_d   = '0;
          state_d   = ST_INT;
          enter_int = 1'b1;
        end
      end
      ST_INT: begin
        if (ctrl_wr) begin
          // A software write in this cycle overrides the hardware EN clear.
          state_d = bus.wr_data[CTRL_EN_BIT] ? ST_LOAD : ST_IDLE;
        end else if (oneshot) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = en_q ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Setting the flag takes priority over an acknowledging CTRL write.
    if (enter_int && oneshot) begin
      flag_d = 1'b1;
    end else if (ctrl_wr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_W'(TC_CTRL)) begin
      rd_data = {28'd0, im_q, mode_q, en_q};
    end else if (addr == ADDR_W'(TC_PRESET)) begin
      rd_data = preset_q;
    end else if (addr == ADDR_W'(TC_COUNT)) begin
      rd_data = count_q;
    end
  end

  assign bus.rd_data = rd_data;
  // Reload mode pulses for the single INT cycle; one-shot holds via the flag.
  assign bus.irq = im_q & (flag_q | ((state_q == ST_INT) && (mode_q == MODE_RELOAD)));

endmodule
